button_decoder: RTL and testbench

BUTTON_DECODER -- requirements
Module: button_decoder

---
 rtl/button_decoder.sv | 142 ++++++++++++++
 tb/tb_button_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/button_decoder.sv
// Push-button front end: synchronizes and debounces an active-low button, then
// classifies each press as short or long and keeps a start/stop run level.
module button_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_0,
  output logic pressed,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic run
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             pressed_q, pressed_d;
  logic             toggle_c, rise_c, fall_c, level_c;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             run_q, run_d;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], button_0};
    end
  end

  assign level_c = ~sync_q[1];

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    pressed_d = pressed_q;
    toggle_c  = 1'b0;
    if (level_c == pressed_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      toggle_c  = 1'b1;
      pressed_d = ~pressed_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  assign rise_c = toggle_c & ~pressed_q;
  assign fall_c = toggle_c &  pressed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      pressed_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // Press classifier; a release on the long-threshold edge wins over long.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (rise_c) begin
          state_d = HELD;
          press_d = 1'b1;
        end
      end
      HELD: begin
        hold_d = hold_q + CNT_W'(1);
        if (fall_c) begin
          state_d = IDLE;
          short_d = 1'b1;
          run_d   = ~run_q;
        end else if (hold_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          run_d   = 1'b0;
        end
      end
      LONG_HELD: begin
        if (fall_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      run_q   <= run_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = press_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign run         = run_q;

endmodule

// File: tb/tb_button_decoder.sv
// Directed bench for button_decoder with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic button_0;
  logic pressed, press_pulse, short_pulse, long_pulse, run;

  int checks = 0;
  int errors = 0;
  int n_press = 0, n_short = 0, n_long = 0, n_multi = 0;
  logic exp_run = 1'b0;

  button_decoder #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_0   (button_0),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .run        (run)
  );

  always #5 clk = ~clk;

  // Pulse tally, settled well before the falling edge where tests read it.
  always @(posedge clk) begin
    #2;
    if (press_pulse === 1'b1) n_press++;
    if (short_pulse === 1'b1) n_short++;
    if (long_pulse  === 1'b1) n_long++;
    if ((int'(press_pulse) + int'(short_pulse) + int'(long_pulse)) > 1) n_multi++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; button_0 = 1'b1;
    step(3);
    checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b want 0", pressed); end
    checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_press_pulse got %b want 0", press_pulse); end
    checks++; if (short_pulse !== 1'b0) begin errors++; $display("FAIL reset_short_pulse got %b want 0", short_pulse); end
    checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL reset_long_pulse got %b want 0", long_pulse); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", run); end
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_glitch();
    int p0;
    p0 = n_press;
    button_0 = 1'b0; step(3);
    button_0 = 1'b1; step(12);
    checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL glitch_pressed got %b want 0", pressed); end
    checks++; if (n_press !== p0) begin errors++; $display("FAIL glitch_press_count got %0d want %0d", n_press, p0); end
    checks++; if (run !== exp_run) begin errors++; $display("FAIL glitch_run got %b want %b", run, exp_run); end
  endtask

  task automatic test_short_press();
    button_0 = 1'b0;
    step(5);
    checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL clean_early_pressed got %b want 0", pressed); end
    step(1);
    checks++; if (pressed !== 1'b1) begin errors++; $display("FAIL clean_pressed got %b want 1", pressed); end
    checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL clean_press_pulse got %b want 1", press_pulse); end
    step(1);
    checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL clean_press_pulse_end got %b want 0", press_pulse); end
    step(9);
    button_0 = 1'b1;
    step(5);
    checks++; if (pressed !== 1'b1 || short_pulse !== 1'b0) begin errors++; $display("FAIL short_early got pressed=%b short=%b want 1 0", pressed, short_pulse); end
    step(1);
    checks++; if (short_pulse !== 1'b1) begin errors++; $display("FAIL short_pulse got %b want 1", short_pulse); end
    checks++; if (pressed !== 1'b0 || long_pulse !== 1'b0) begin errors++; $display("FAIL short_levels got pressed=%b long=%b want 0 0", pressed, long_pulse); end
    exp_run = ~exp_run;
    step(1);
    checks++; if (short_pulse !== 1'b0) begin errors++; $display("FAIL short_pulse_end got %b want 0", short_pulse); end
    checks++; if (run !== exp_run) begin errors++; $display("FAIL short_run got %b want %b", run, exp_run); end
  endtask

  task automatic test_long_press();
    int s0, l0;
    s0 = n_short; l0 = n_long;
    button_0 = 1'b0;
    step(6);
    checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL long_press_pulse got %b want 1", press_pulse); end
    step(19);
    checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL long_early got %b want 0", long_pulse); end
    step(1);
    checks++; if (long_pulse !== 1'b1 || short_pulse !== 1'b0) begin errors++; $display("FAIL long_pulse got long=%b short=%b want 1 0", long_pulse, short_pulse); end
    exp_run = 1'b0;
    step(1);
    checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL long_pulse_end got %b want 0", long_pulse); end
    checks++; if (run !== exp_run) begin errors++; $display("FAIL long_run got %b want %b", run, exp_run); end
    step(9);
    button_0 = 1'b1;
    step(10);
    checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL long_release_pressed got %b want 0", pressed); end
    checks++; if (n_short !== s0) begin errors++; $display("FAIL long_no_short got %0d want %0d", n_short, s0); end
    checks++; if (n_long !== l0 + 1) begin errors++; $display("FAIL long_once got %0d want %0d", n_long, l0 + 1); end
  endtask

  task automatic test_boundary();
    int l0;
    l0 = n_long;
    button_0 = 1'b0;
    step(6);
    checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL bound_press_pulse got %b want 1", press_pulse); end
    step(14);
    button_0 = 1'b1;
    step(6);
    checks++; if (short_pulse !== 1'b1 || long_pulse !== 1'b0) begin errors++; $display("FAIL bound_pulses got short=%b long=%b want 1 0", short_pulse, long_pulse); end
    exp_run = ~exp_run;
    step(3);
    checks++; if (n_long !== l0) begin errors++; $display("FAIL bound_no_long got %0d want %0d", n_long, l0); end
    checks++; if (run !== exp_run) begin errors++; $display("FAIL bound_run got %b want %b", run, exp_run); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      button_0 = 1'b0;
      step(6);
      checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL b2b_press_pulse_%0d got %b want 1", i, press_pulse); end
      step(3);
      button_0 = 1'b1;
      step(6);
      checks++; if (short_pulse !== 1'b1) begin errors++; $display("FAIL b2b_short_%0d got %b want 1", i, short_pulse); end
      exp_run = ~exp_run;
      step(1);
      checks++; if (run !== exp_run) begin errors++; $display("FAIL b2b_run_%0d got %b want %b", i, run, exp_run); end
    end
  endtask

  task automatic test_reset_mid_press();
    int p0, s0, l0;
    button_0 = 1'b0;
    step(6);
    checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL rmid_press_pulse got %b want 1", press_pulse); end
    step(4);
    rst_n = 1'b0;
    #1;
    checks++; if (pressed !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL rmid_levels got pressed=%b run=%b want 0 0", pressed, run); end
    checks++; if (press_pulse !== 1'b0 || short_pulse !== 1'b0 || long_pulse !== 1'b0) begin errors++; $display("FAIL rmid_pulses got %b%b%b want 000", press_pulse, short_pulse, long_pulse); end
    exp_run = 1'b0;
    p0 = n_press; s0 = n_short; l0 = n_long;
    button_0 = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(25);
    checks++; if (n_press !== p0 || n_short !== s0 || n_long !== l0) begin errors++; $display("FAIL rmid_no_pulses got %0d %0d %0d want %0d %0d %0d", n_press, n_short, n_long, p0, s0, l0); end
    checks++; if (pressed !== 1'b0 || run !== exp_run) begin errors++; $display("FAIL rmid_after got pressed=%b run=%b want 0 %b", pressed, run, exp_run); end
  endtask

  task automatic test_reset_held();
    rst_n = 1'b0; button_0 = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    checks++; if (pressed !== 1'b0 || press_pulse !== 1'b0) begin errors++; $display("FAIL rheld_early got pressed=%b pulse=%b want 0 0", pressed, press_pulse); end
    step(1);
    checks++; if (press_pulse !== 1'b1) begin errors++; $display("FAIL rheld_press_pulse got %b want 1", press_pulse); end
    step(2);
    button_0 = 1'b1;
    step(6);
    checks++; if (short_pulse !== 1'b1) begin errors++; $display("FAIL rheld_short got %b want 1", short_pulse); end
    exp_run = ~exp_run;
    step(1);
    checks++; if (run !== exp_run) begin errors++; $display("FAIL rheld_run got %b want %b", run, exp_run); end
  endtask

  task automatic test_exclusive();
    checks++; if (n_multi !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d overlaps want 0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_boundary();
    test_back_to_back();
    test_reset_mid_press();
    test_reset_held();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
